// File: rtl/decode_packet_pkg.sv
// Shared flit format and frame constants for the lane packet encoder/decoder pair.
package decode_packet_pkg;

  localparam int unsigned DATA_WIDTH        = 1024;
  localparam int unsigned ADDR_WIDTH        = 10;
  localparam int unsigned DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH;
  localparam int unsigned AURORA_DATA_WIDTH = 256;
  localparam int unsigned NUMBER_PACKET     = 5;

  localparam int unsigned SRC_LSB       = 0;
  localparam int unsigned SRC_WIDTH     = 2;
  localparam int unsigned PKT_NUM_LSB   = 2;
  localparam int unsigned PKT_NUM_WIDTH = 5;
  localparam int unsigned TTL_LSB       = 7;
  localparam int unsigned TTL_WIDTH     = 2;
  localparam int unsigned HEADER_WIDTH  = 9;
  localparam int unsigned PAYLOAD_WIDTH = AURORA_DATA_WIDTH - HEADER_WIDTH;

  // Bits carried by the final flit of a frame.
  localparam int unsigned LAST_WIDTH = DATA_DFX_WIDTH - (NUMBER_PACKET - 1) * PAYLOAD_WIDTH;

  localparam logic [PKT_NUM_WIDTH-1:0] LAST_PKT    = PKT_NUM_WIDTH'(NUMBER_PACKET - 1);
  localparam logic [TTL_WIDTH-1:0]     DEFAULT_TTL = 2'd3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDone    = 2'd2
  } state_e;

endpackage

// File: rtl/decode_packet_if.sv
// Flit receive and DFX word handshake bundle; slave is the decoder, master its environment.
interface decode_packet_if;
  import decode_packet_pkg::*;

  logic                         decode_valid;
  logic [AURORA_DATA_WIDTH-1:0] data_recv;
  logic                         decode_ready;
  logic                         dfx_valid;
  logic                         dfx_ready;
  logic [DATA_DFX_WIDTH-1:0]    data_dfx_recv;
  logic [SRC_WIDTH-1:0]         recv_src_router;
  logic [TTL_WIDTH-1:0]         recv_ttl;
  logic                         seq_err;

  modport master (
    output decode_valid, data_recv, dfx_ready,
    input  decode_ready, dfx_valid, data_dfx_recv, recv_src_router, recv_ttl, seq_err
  );

  modport slave (
    input  decode_valid, data_recv, dfx_ready,
    output decode_ready, dfx_valid, data_dfx_recv, recv_src_router, recv_ttl, seq_err
  );

endinterface

// File: rtl/decode_packet.sv
// Reassembles NUMBER_PACKET Aurora flits into one DFX word with header sequence checking.
// Define DECODE_PKT_ERR_CNT_EN to add the saturating header-error counter output err_cnt.
module decode_packet
  import decode_packet_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  decode_packet_if.slave bus
`ifdef DECODE_PKT_ERR_CNT_EN
  ,
  output logic [15:0]    err_cnt
`endif
);

  state_e                    r_state, w_state_d;
  logic [PKT_NUM_WIDTH-1:0]  r_expected, w_expected_d;
  logic [DATA_DFX_WIDTH-1:0] r_data;
  logic [SRC_WIDTH-1:0]      r_src;
  logic [TTL_WIDTH-1:0]      r_ttl;
  logic                      r_seq_err, w_seq_err_d;
  logic                      w_accept, w_store, w_new_frame;

  logic [SRC_WIDTH-1:0]      w_src;
  logic [PKT_NUM_WIDTH-1:0]  w_pkt;
  logic [TTL_WIDTH-1:0]      w_ttl;
  logic [PAYLOAD_WIDTH-1:0]  w_payload;

  assign w_src     = bus.data_recv[SRC_LSB +: SRC_WIDTH];
  assign w_pkt     = bus.data_recv[PKT_NUM_LSB +: PKT_NUM_WIDTH];
  assign w_ttl     = bus.data_recv[TTL_LSB +: TTL_WIDTH];
  assign w_payload = bus.data_recv[HEADER_WIDTH +: PAYLOAD_WIDTH];

  // Held low while reset is asserted even though the state already reads idle.
  assign bus.decode_ready = (r_state != StDone) && !rst;
  assign w_accept         = bus.decode_valid && bus.decode_ready;

  always_comb begin
    w_state_d    = r_state;
    w_expected_d = r_expected;
    w_seq_err_d  = 1'b0;
    w_store      = 1'b0;
    w_new_frame  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_pkt == '0) begin
            w_store      = 1'b1;
            w_new_frame  = 1'b1;
            w_expected_d = PKT_NUM_WIDTH'(1);
            w_state_d    = StCollect;
          end else begin
            w_seq_err_d = 1'b1;
          end
        end
      end
      StCollect: begin
        if (w_accept) begin
          if (w_pkt == r_expected && w_src == r_src) begin
            w_store      = 1'b1;
            w_expected_d = r_expected + PKT_NUM_WIDTH'(1);
            if (w_pkt == LAST_PKT) w_state_d = StDone;
          end else begin
            w_seq_err_d = 1'b1;
            if (w_pkt == '0) begin
              // A fresh flit 0 restarts the frame instead of being dropped.
              w_store      = 1'b1;
              w_new_frame  = 1'b1;
              w_expected_d = PKT_NUM_WIDTH'(1);
            end else begin
              w_expected_d = '0;
              w_state_d    = StIdle;
            end
          end
        end
      end
      StDone: begin
        if (bus.dfx_ready) begin
          w_expected_d = '0;
          w_state_d    = StIdle;
        end
      end
      default: begin
        w_expected_d = '0;
        w_state_d    = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_expected <= '0;
      r_seq_err  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_expected <= w_expected_d;
      r_seq_err  <= w_seq_err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_src  <= '0;
      r_ttl  <= '0;
    end else begin
      if (w_store) begin
        for (int k = 0; k < NUMBER_PACKET - 1; k++) begin
          if (w_pkt == PKT_NUM_WIDTH'(k)) r_data[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] <= w_payload;
        end
        if (w_pkt == LAST_PKT) r_data[DATA_DFX_WIDTH-1 -: LAST_WIDTH] <= w_payload[LAST_WIDTH-1:0];
      end
      if (w_new_frame) begin
        r_src <= w_src;
        r_ttl <= w_ttl;
      end
    end
  end

`ifdef DECODE_PKT_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_seq_err_d && r_err_cnt != 16'hFFFF) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

  assign bus.dfx_valid       = (r_state == StDone);
  assign bus.data_dfx_recv   = r_data;
  assign bus.recv_src_router = r_src;
  assign bus.recv_ttl        = r_ttl;
  assign bus.seq_err         = r_seq_err;

endmodule

// File: tb/tb_decode_packet.sv
// Directed bench for decode_packet: flit-sequence table plus hold, reset and gap sequences.
module tb_decode_packet;
  import decode_packet_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  decode_packet_if bus ();
`ifdef DECODE_PKT_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  decode_packet u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DECODE_PKT_ERR_CNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] pkt;
    logic [1:0] src;
    logic [1:0] ttl;
    logic [7:0] pat;
    logic       err;
    logic       done;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [PAYLOAD_WIDTH-1:0] payload(logic [4:0] pkt, logic [7:0] pat);
    logic [PAYLOAD_WIDTH-1:0] p;
    for (int b = 0; b < PAYLOAD_WIDTH; b++) p[b] = pat[3'((b + int'(pkt)) % 8)];
    return p;
  endfunction

  function automatic logic [AURORA_DATA_WIDTH-1:0] flit(logic [4:0] pkt, logic [1:0] src,
                                                         logic [1:0] ttl, logic [7:0] pat);
    return {payload(pkt, pat), ttl, pkt, src};
  endfunction

  function automatic logic [DATA_DFX_WIDTH-1:0] frame_word(logic [4:0][7:0] pats);
    logic [DATA_DFX_WIDTH-1:0] w;
    logic [PAYLOAD_WIDTH-1:0]  p;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      p = payload(5'(k), pats[k]);
      w[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = p;
    end
    p = payload(5'd4, pats[4]);
    w[1033:988] = p[45:0];
    return w;
  endfunction

  task automatic add(logic [4:0] pkt, logic [1:0] src, logic [1:0] ttl, logic [7:0] pat,
                     logic err, logic done);
    vecs.push_back('{pkt: pkt, src: src, ttl: ttl, pat: pat, err: err, done: done});
  endtask

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic check_word(string name, logic [DATA_DFX_WIDTH-1:0] got,
                            logic [DATA_DFX_WIDTH-1:0] exp);
    logic [DATA_DFX_WIDTH-1:0] gs, es;
    int bit_i;
    checks++;
    if (got !== exp) begin
      failures++;
      bit_i = 0;
      for (int i = DATA_DFX_WIDTH - 1; i >= 0; i--) if (got[i] !== exp[i]) bit_i = i;
      gs = got >> ((bit_i / 32) * 32);
      es = exp >> ((bit_i / 32) * 32);
      $display("FAIL %s first bad bit %0d chunk got=%08h exp=%08h", name, bit_i, gs[31:0],
               es[31:0]);
    end
  endtask

  task automatic send(logic [4:0] pkt, logic [1:0] src, logic [1:0] ttl, logic [7:0] pat,
                      int gap);
    repeat (gap) @(posedge clk);
    @(negedge clk);
    check("decode_ready_before_flit", bus.decode_ready, 1);
    bus.decode_valid = 1'b1;
    bus.data_recv    = flit(pkt, src, ttl, pat);
    @(posedge clk);
    #1;
    bus.decode_valid = 1'b0;
  endtask

  task automatic accept_word();
    @(negedge clk);
    bus.dfx_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.dfx_ready = 1'b0;
    check("dfx_valid_after_accept", bus.dfx_valid, 0);
    check("decode_ready_after_accept", bus.decode_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t            v;
    logic [4:0][7:0] pats;
    int              n_err;

    bus.decode_valid = 1'b0;
    bus.data_recv    = '0;
    bus.dfx_ready    = 1'b0;
    n_err            = 0;

    // In-order frame, stray flit in idle, skipped flit, restarted frame, source change.
    add(0, 1, 2, 8'hAA, 0, 0); add(1, 1, 2, 8'h55, 0, 0); add(2, 1, 2, 8'hC3, 0, 0);
    add(3, 1, 2, 8'h3C, 0, 0); add(4, 1, 2, 8'h0F, 0, 1);
    add(2, 1, 2, 8'h11, 1, 0);
    add(0, 2, 1, 8'h21, 0, 0); add(1, 2, 1, 8'h22, 0, 0); add(3, 2, 1, 8'h23, 1, 0);
    add(0, 2, 1, 8'h31, 0, 0); add(1, 2, 1, 8'h32, 0, 0); add(2, 2, 1, 8'h33, 0, 0);
    add(3, 2, 1, 8'h34, 0, 0); add(4, 2, 1, 8'h35, 0, 1);
    add(0, 3, 3, 8'h41, 0, 0); add(1, 3, 3, 8'h42, 0, 0); add(0, 3, 3, 8'h51, 1, 0);
    add(1, 3, 3, 8'h52, 0, 0); add(2, 3, 3, 8'h53, 0, 0); add(3, 3, 3, 8'h54, 0, 0);
    add(4, 3, 3, 8'h55, 0, 1);
    add(0, 1, 0, 8'h61, 0, 0); add(1, 1, 0, 8'h62, 0, 0); add(2, 2, 0, 8'h63, 1, 0);
    add(0, 0, 1, 8'h71, 0, 0); add(1, 0, 1, 8'h72, 0, 0); add(2, 0, 1, 8'h73, 0, 0);
    add(3, 0, 1, 8'h74, 0, 0); add(4, 0, 1, 8'h75, 0, 1);

    repeat (2) @(posedge clk);
    #1;
    check("reset_decode_ready", bus.decode_ready, 0);
    check("reset_dfx_valid", bus.dfx_valid, 0);
    check("reset_seq_err", bus.seq_err, 0);
    check_word("reset_data", bus.data_dfx_recv, '0);
    check("reset_src", bus.recv_src_router, 0);
    check("reset_ttl", bus.recv_ttl, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("decode_ready_after_reset", bus.decode_ready, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      send(v.pkt, v.src, v.ttl, v.pat, 0);
      check($sformatf("seq_err_vec%0d", i), bus.seq_err, v.err);
      check($sformatf("dfx_valid_vec%0d", i), bus.dfx_valid, v.done);
      if (v.err) n_err++;
      if (v.done && i >= 4) begin
        for (int k = 0; k < 5; k++) pats[k] = vecs[i-4+k].pat;
        check_word($sformatf("word_vec%0d", i), bus.data_dfx_recv, frame_word(pats));
        check($sformatf("src_vec%0d", i), bus.recv_src_router, vecs[i-4].src);
        check($sformatf("ttl_vec%0d", i), bus.recv_ttl, vecs[i-4].ttl);
        accept_word();
      end
    end

    // Word held with dfx_ready low: no flits accepted, outputs stable.
    for (int k = 0; k < 5; k++) begin
      pats[k] = 8'(8'h81 + k);
      send(5'(k), 2'd1, 2'd2, pats[k], 0);
    end
    check("hold_dfx_valid_first", bus.dfx_valid, 1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check("hold_decode_ready", bus.decode_ready, 0);
      check("hold_dfx_valid", bus.dfx_valid, 1);
      check_word("hold_word", bus.data_dfx_recv, frame_word(pats));
    end
    accept_word();

`ifdef DECODE_PKT_ERR_CNT_EN
    check("err_cnt_total", err_cnt, 64'(n_err));
`endif

    // Reset mid-frame, then a full frame with 3-cycle valid gaps.
    send(5'd0, 2'd2, 2'd3, 8'h91, 0);
    send(5'd1, 2'd2, 2'd3, 8'h92, 0);
    send(5'd2, 2'd2, 2'd3, 8'h93, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_decode_ready", bus.decode_ready, 0);
    check("midrst_dfx_valid", bus.dfx_valid, 0);
    check_word("midrst_data", bus.data_dfx_recv, '0);
    check("midrst_src", bus.recv_src_router, 0);
    check("midrst_ttl", bus.recv_ttl, 0);
`ifdef DECODE_PKT_ERR_CNT_EN
    check("midrst_err_cnt", err_cnt, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pats[k] = 8'(8'hA1 + k);
      send(5'(k), 2'd2, 2'd3, pats[k], 3);
      check("gap_seq_err", bus.seq_err, 0);
      check("gap_dfx_valid", bus.dfx_valid, (k == 4));
    end
    check_word("gap_word", bus.data_dfx_recv, frame_word(pats));
    check("gap_src", bus.recv_src_router, 2);
    check("gap_ttl", bus.recv_ttl, 3);
    accept_word();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_packet.md
# decode_packet

Receive-side counterpart of the lane packet encoder. Accepts 256-bit Aurora flits from the lane receive FIFO, checks each flit header, and reassembles NUMBER_PACKET flits into one DATA_DFX_WIDTH-bit DFX word (data + address). The reassembled word, with the source router and TTL of the frame, is presented to the decode controller over a valid/ready handshake.

## Interface
- DATA_WIDTH, 1024, payload data bits of a DFX word
- ADDR_WIDTH, 10, address bits of a DFX word
- DATA_DFX_WIDTH, DATA_WIDTH+ADDR_WIDTH (1034), reassembled word width
- AURORA_DATA_WIDTH, 256, flit width
- NUMBER_PACKET, 5, flits per frame (ceil(1034/247))
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- decode_valid  in  1  flit present on data_recv
- data_recv  in  AURORA_DATA_WIDTH  flit
- decode_ready  out  1  block accepts a flit this cycle
- dfx_valid  out  1  reassembled word valid, held until accepted
- dfx_ready  in  1  decode controller accepts word
- data_dfx_recv  out  DATA_DFX_WIDTH  reassembled word
- recv_src_router  out  2  source router of frame
- recv_ttl  out  2  TTL of frame
- seq_err  out  1  one-cycle pulse: flit dropped for header error

## Operation
- Flit layout: [1:0] src_router, [6:2] pkt_number, [8:7] TTL, [255:9] payload (247 bits).
- Flit k (k < NUMBER_PACKET-1) supplies data_dfx_recv[k*247 +: 247]; last flit supplies [1033:988] from flit bits [54:9]; flit bits [255:55] of last flit ignored.
- Accept = decode_valid && decode_ready.
- States: IDLE, COLLECT, DONE.
- IDLE: decode_ready=1. Accepted flit with pkt_number 0 → store payload, latch src_router/TTL, expected=1, → COLLECT. Any other pkt_number → drop, seq_err pulse, stay IDLE.
- COLLECT: decode_ready=1. Accepted flit with pkt_number==expected and src_router==latched → store, expected+1; if pkt_number==NUMBER_PACKET-1 → DONE. Mismatch → seq_err pulse, discard partial frame; if offending flit has pkt_number 0 it starts a new frame (stay COLLECT, expected=1), else → IDLE.
- DONE: decode_ready=0, dfx_valid=1, outputs stable. dfx_valid && dfx_ready → IDLE.
- Unwritten bits of data_dfx_recv are not cleared between frames; every bit is overwritten by a complete frame.
- Reset: state IDLE, expected 0, decode_ready 0 during reset (1 first cycle after), dfx_valid 0, seq_err 0, data_dfx_recv 0, recv_src_router 0, recv_ttl 0. Reset mid-frame discards partial frame.

## Timing
- Payload write registered on accept edge.
- Last flit accepted in cycle N → dfx_valid=1 in cycle N+1.
- Word accepted in cycle M → dfx_valid=0, decode_ready=1 in cycle M+1.
- Minimum frame period NUMBER_PACKET+1 cycles; decode_valid gaps between flits allowed, no timeout.
- seq_err asserted in cycle after the offending accept, for exactly one cycle.
- decode_ready is a decode of state only (no combinational path from dfx_ready).

## Configuration
- DECODE_PKT_ERR_CNT_EN defined: adds output err_cnt [15:0], incremented on every seq_err pulse, saturating at 16'hFFFF, reset to 0.
- Undefined: no err_cnt port, no counter logic; all other behaviour identical.

## Structure
- Shared package (common with encoder): flit field offsets/widths (SRC_LSB, PKT_NUM_LSB, TTL_LSB, HEADER_WIDTH=9, PAYLOAD_WIDTH=247), NUMBER_PACKET, state encodings, default TTL.
- Single module; no sub-module needed. Optional sub-module pkt_header_check (combinational field extraction + compare) if shared with router lanes.

## Test plan
- Five in-order flits, payload k = {247{k[0]}} pattern per flit, src 2'b01, TTL 2'b10 → data_dfx_recv matches concatenation, recv_src_router=1, recv_ttl=2, dfx_valid one cycle after flit 4.
- dfx_ready held low 4 cycles after dfx_valid → decode_ready 0, word stable, then one-cycle accept → IDLE; next frame decodes correctly.
- Flits 0,1,3 → seq_err pulse after flit 3, state IDLE; following full frame 0..4 decodes correctly.
- Flits 0,1 then new flit 0 with different payload → seq_err pulse, new frame completes with only new payload.
- Flit 2 with src_router changed → seq_err, frame dropped; with DECODE_PKT_ERR_CNT_EN err_cnt=1.
- rst asserted after flit 2, released, full frame → outputs 0 during reset, correct word after; valid gaps of 3 cycles between flits tolerated.
